// File: rtl/panda_pipeline_controller_if.sv
// Control bundle between the Panda pipeline stages and the stall/flush sequencer.
interface panda_pipeline_controller_if #(
    parameter int unsigned CntWidth = 16
);
    logic                id_valid_i;
    logic [4:0]          id_rs1_addr_i;
    logic [4:0]          id_rs2_addr_i;
    logic                id_rs1_used_i;
    logic                id_rs2_used_i;
    logic                id_illegal_instr_i;
    logic [4:0]          ex_rd_addr_i;
    logic                ex_rd_we_i;
    logic                ex_load_i;
    logic                ex_branch_taken_i;
    logic                ex_jump_i;
    logic                lsu_req_i;
    logic                lsu_gnt_i;
    logic                if_stall_o;
    logic                id_stall_o;
    logic                ex_stall_o;
    logic                if_flush_o;
    logic                id_flush_o;
    logic                pc_redirect_o;
    logic                halted_o;
    logic [CntWidth-1:0] stall_cycles_o;
    logic [CntWidth-1:0] flush_count_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_illegal_instr_i, ex_rd_addr_i, ex_rd_we_i, ex_load_i,
               ex_branch_taken_i, ex_jump_i, lsu_req_i, lsu_gnt_i,
        input  if_stall_o, id_stall_o, ex_stall_o, if_flush_o, id_flush_o,
               pc_redirect_o, halted_o, stall_cycles_o, flush_count_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_illegal_instr_i, ex_rd_addr_i, ex_rd_we_i, ex_load_i,
               ex_branch_taken_i, ex_jump_i, lsu_req_i, lsu_gnt_i,
        output if_stall_o, id_stall_o, ex_stall_o, if_flush_o, id_flush_o,
               pc_redirect_o, halted_o, stall_cycles_o, flush_count_o
    );
endinterface

// File: rtl/panda_pipeline_controller.sv
// Stall/flush sequencer for the Panda 5-stage core: boot hold, load-use and
// memory stalls, branch redirects, illegal-instruction halt, perf counters.
module panda_pipeline_controller #(
    parameter int unsigned BootCycles = 2,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    panda_pipeline_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e              state, state_next;
    logic [7:0]          boot_cnt;
    logic [CntWidth-1:0] stall_cnt;
    logic [CntWidth-1:0] flush_cnt;

    logic memstall, redirect, load_use, illegal;
    logic if_stall, id_stall, ex_stall, if_flush, id_flush, pc_redirect, halted;

    assign memstall = bus.lsu_req_i & ~bus.lsu_gnt_i;
    assign redirect = bus.ex_branch_taken_i | bus.ex_jump_i;
    assign illegal  = bus.id_valid_i & bus.id_illegal_instr_i;
    assign load_use = bus.ex_load_i & bus.ex_rd_we_i & (bus.ex_rd_addr_i != 5'd0) & bus.id_valid_i &
                      ((bus.id_rs1_used_i & (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) |
                       (bus.id_rs2_used_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_stall    = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        unique case (state)
            BOOT: begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
                if (boot_cnt == 8'd1) state_next = RUN;
            end
            RUN, MEM_WAIT: begin
                // The grant cycle of MEM_WAIT falls through to the RUN priority chain.
                state_next = RUN;
                if ((state == MEM_WAIT) && !bus.lsu_gnt_i) begin
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    ex_stall   = 1'b1;
                    state_next = MEM_WAIT;
                end else if (memstall) begin
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    ex_stall   = 1'b1;
                    state_next = MEM_WAIT;
                end else if (redirect) begin
                    if_flush    = 1'b1;
                    id_flush    = 1'b1;
                    pc_redirect = 1'b1;
                end else if (load_use) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    id_flush = 1'b1;
                end else if (illegal) begin
                    id_flush   = 1'b1;
                    state_next = HALT;
                end
            end
            HALT: begin
                halted   = 1'b1;
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
                ex_stall = memstall;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            boot_cnt  <= 8'(BootCycles);
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == BOOT) boot_cnt <= boot_cnt - 8'd1;
            if (((state == RUN) || (state == MEM_WAIT)) && if_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (pc_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.if_stall_o     = if_stall;
    assign bus.id_stall_o     = id_stall;
    assign bus.ex_stall_o     = ex_stall;
    assign bus.if_flush_o     = if_flush;
    assign bus.id_flush_o     = id_flush;
    assign bus.pc_redirect_o  = pc_redirect;
    assign bus.halted_o       = halted;
    assign bus.stall_cycles_o = stall_cnt;
    assign bus.flush_count_o  = flush_cnt;

endmodule

// File: tb/tb_panda_pipeline_controller.sv
// Directed scoreboard bench for panda_pipeline_controller (BootCycles=2, CntWidth=4).
module tb_panda_pipeline_controller;

    localparam int unsigned CW = 4;

    // {if_stall, id_stall, ex_stall, if_flush, id_flush, pc_redirect, halted}
    localparam logic [6:0] BOOTO = 7'b1100100;
    localparam logic [6:0] RUNO  = 7'b0000000;
    localparam logic [6:0] MEMO  = 7'b1110000;
    localparam logic [6:0] REDO  = 7'b0001110;
    localparam logic [6:0] LUO   = 7'b1100100;
    localparam logic [6:0] ILLO  = 7'b0000100;
    localparam logic [6:0] HALTO = 7'b1100101;
    localparam logic [6:0] HALTM = 7'b1110101;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   tests = 0;
    int   fails = 0;
    logic [CW-1:0] sc_m = '0;
    logic [CW-1:0] fc_m = '0;
    exp_t  exp_q[$];
    string tag_q[$];

    panda_pipeline_controller_if #(.CntWidth(CW)) bus ();

    panda_pipeline_controller #(
        .BootCycles(2),
        .CntWidth  (CW)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.id_valid_i         = 1'b0;
        bus.id_rs1_addr_i      = 5'd0;
        bus.id_rs2_addr_i      = 5'd0;
        bus.id_rs1_used_i      = 1'b0;
        bus.id_rs2_used_i      = 1'b0;
        bus.id_illegal_instr_i = 1'b0;
        bus.ex_rd_addr_i       = 5'd0;
        bus.ex_rd_we_i         = 1'b0;
        bus.ex_load_i          = 1'b0;
        bus.ex_branch_taken_i  = 1'b0;
        bus.ex_jump_i          = 1'b0;
        bus.lsu_req_i          = 1'b0;
        bus.lsu_gnt_i          = 1'b0;
    endtask

    // Push expectation for the current cycle, compare at negedge, advance the counter model.
    task automatic cyc(input logic [6:0] ctl, input bit inc_s, input bit inc_f, input string tag);
        exp_t  e;
        string t;
        logic [6:0] obs;
        exp_q.push_back('{ctl: ctl, sc: sc_m, fc: fc_m});
        tag_q.push_back(tag);
        @(negedge clk_i);
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o, bus.if_flush_o,
               bus.id_flush_o, bus.pc_redirect_o, bus.halted_o};
        tests++;
        assert (obs === e.ctl) else begin
            fails++;
            $error("FAIL %s ctl observed=%b expected=%b", t, obs, e.ctl);
        end
        tests++;
        assert (bus.stall_cycles_o === e.sc) else begin
            fails++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", t, bus.stall_cycles_o, e.sc);
        end
        tests++;
        assert (bus.flush_count_o === e.fc) else begin
            fails++;
            $error("FAIL %s flush_count observed=%0d expected=%0d", t, bus.flush_count_o, e.fc);
        end
        if (inc_s && sc_m != 4'hF) sc_m = sc_m + 4'd1;
        if (inc_f && fc_m != 4'hF) fc_m = fc_m + 4'd1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        #2;
        cyc(BOOTO, 0, 0, "reset");
        rst_ni = 1'b1;
        cyc(BOOTO, 0, 0, "boot1");
        cyc(BOOTO, 0, 0, "boot2");
        cyc(RUNO,  0, 0, "run");

        // Load-use on rs2
        bus.ex_load_i = 1'b1; bus.ex_rd_we_i = 1'b1; bus.ex_rd_addr_i = 5'd5;
        bus.id_valid_i = 1'b1; bus.id_rs2_addr_i = 5'd5; bus.id_rs2_used_i = 1'b1;
        cyc(LUO, 1, 0, "lu_rs2");
        bus.ex_load_i = 1'b0;
        cyc(RUNO, 0, 0, "lu_after");
        bus.ex_load_i = 1'b1; bus.ex_rd_addr_i = 5'd0; bus.id_rs2_addr_i = 5'd0;
        cyc(RUNO, 0, 0, "lu_rd0");
        bus.ex_rd_addr_i = 5'd5; bus.id_rs2_addr_i = 5'd5; bus.id_rs2_used_i = 1'b0;
        cyc(RUNO, 0, 0, "lu_unused");
        bus.ex_rd_addr_i = 5'd7; bus.id_rs1_addr_i = 5'd7; bus.id_rs1_used_i = 1'b1;
        cyc(LUO, 1, 0, "lu_rs1");
        bus.id_valid_i = 1'b0;
        cyc(RUNO, 0, 0, "lu_bubble");
        clear_inputs();

        // Memory stall with a held branch
        bus.lsu_req_i = 1'b1; bus.ex_branch_taken_i = 1'b1;
        cyc(MEMO, 1, 0, "mem1");
        cyc(MEMO, 1, 0, "mem2");
        cyc(MEMO, 1, 0, "mem3");
        bus.lsu_gnt_i = 1'b1;
        cyc(REDO, 0, 1, "mem_gnt");
        clear_inputs();
        cyc(RUNO, 0, 0, "mem_done");
        bus.lsu_req_i = 1'b1; bus.lsu_gnt_i = 1'b1;
        cyc(RUNO, 0, 0, "gnt_same");
        clear_inputs();

        // Jump squashes an illegal instruction
        bus.ex_jump_i = 1'b1; bus.id_valid_i = 1'b1; bus.id_illegal_instr_i = 1'b1;
        cyc(REDO, 0, 1, "jump_ill");
        clear_inputs();
        cyc(RUNO, 0, 0, "no_halt");
        bus.id_illegal_instr_i = 1'b1;
        cyc(RUNO, 0, 0, "ill_invalid");

        // Load-use beats illegal, then halt
        bus.id_valid_i = 1'b1; bus.ex_load_i = 1'b1; bus.ex_rd_we_i = 1'b1;
        bus.ex_rd_addr_i = 5'd3; bus.id_rs1_addr_i = 5'd3; bus.id_rs1_used_i = 1'b1;
        cyc(LUO, 1, 0, "lu_ill");
        bus.ex_load_i = 1'b0;
        cyc(ILLO, 0, 0, "ill");
        clear_inputs();
        cyc(HALTO, 0, 0, "halt");
        bus.lsu_req_i = 1'b1;
        cyc(HALTM, 0, 0, "halt_mem");
        bus.lsu_gnt_i = 1'b1;
        cyc(HALTO, 0, 0, "halt_gnt");

        // Asynchronous reset from HALT
        clear_inputs();
        rst_ni = 1'b0;
        sc_m = '0;
        fc_m = '0;
        cyc(BOOTO, 0, 0, "halt_reset");
        rst_ni = 1'b1;
        cyc(BOOTO, 0, 0, "reboot1");
        cyc(BOOTO, 0, 0, "reboot2");
        cyc(RUNO,  0, 0, "rerun");

        // Counter saturation with a long memory stall
        bus.lsu_req_i = 1'b1;
        for (int i = 0; i < 17; i++) cyc(MEMO, 1, 0, "sat_mem");
        bus.lsu_gnt_i = 1'b1;
        cyc(RUNO, 0, 0, "sat_gnt");
        clear_inputs();
        cyc(RUNO, 0, 0, "sat_hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/panda_pipeline_controller.md
# panda_pipeline_controller

Central stall/flush sequencer for the Panda 5-stage core. It watches the operand addresses and validity of the instruction in ID, the destination and type of the instruction in EX, branch/jump resolution, and the data-memory handshake. From these it drives per-stage stall and flush enables for the IF/ID and ID/EX pipeline registers and the EX stage. It also holds a boot/halt state machine and saturating performance counters.

## Interface
- `BootCycles`, 2: cycles fetch is held after reset release; legal range 1..255.
- `CntWidth`, 16: width of each performance counter.

- `clk_i`  in  1  core clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `id_valid_i`  in  1  ID holds a real (non-bubble) instruction
- `id_rs1_addr_i` / `id_rs2_addr_i`  in  5 each  source registers of the ID instruction
- `id_rs1_used_i` / `id_rs2_used_i`  in  1 each  source register is actually read
- `id_illegal_instr_i`  in  1  decoder flagged the ID instruction illegal
- `ex_rd_addr_i`  in  5  destination register of the EX instruction
- `ex_rd_we_i`  in  1  EX instruction writes rd
- `ex_load_i`  in  1  EX instruction is a load
- `ex_branch_taken_i` / `ex_jump_i`  in  1 each  taken branch / jump resolved in EX
- `lsu_req_i`  in  1  LSU is presenting a data-memory request
- `lsu_gnt_i`  in  1  memory accepted the request this cycle
- `if_stall_o`  out  1  hold the PC and the IF/ID register
- `id_stall_o`  out  1  hold the ID/EX register inputs; ID does not advance
- `ex_stall_o`  out  1  hold EX and its output register
- `if_flush_o`  out  1  load a bubble into IF/ID
- `id_flush_o`  out  1  load a bubble into ID/EX (`rd_we`, `lsu_store`, `branch`, `jump` = 0)
- `pc_redirect_o`  out  1  PC takes the EX target
- `halted_o`  out  1  core halted on an illegal instruction
- `stall_cycles_o`  out  CntWidth  saturating count of stall cycles
- `flush_count_o`  out  CntWidth  saturating count of redirects

## Operation
- FSM states: BOOT, RUN, MEM_WAIT, HALT. Reset enters BOOT and loads the boot counter with BootCycles.
- BOOT:
  - Outputs: `if_stall_o`=1, `id_stall_o`=1, `id_flush_o`=1, all others 0.
  - The counter decrements each cycle. Transition to RUN on the cycle it reads 1, so BOOT lasts exactly BootCycles cycles.
- Definition: memstall = `lsu_req_i` & ~`lsu_gnt_i`.
- RUN, evaluated in priority order:
  1. memstall: `if_stall_o`=`id_stall_o`=`ex_stall_o`=1. Next state MEM_WAIT.
  2. redirect (`ex_branch_taken_i` | `ex_jump_i`): `if_flush_o`=`id_flush_o`=`pc_redirect_o`=1. Stay in RUN.
  3. load-use: `ex_load_i` & `ex_rd_we_i` & `ex_rd_addr_i`≠0 & `id_valid_i` & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)). Outputs `if_stall_o`=`id_stall_o`=1 and `id_flush_o`=1, giving one bubble. Stay in RUN.
  4. illegal: `id_valid_i` & `id_illegal_instr_i`. Output `id_flush_o`=1 (the illegal instruction never enters EX). Next state HALT.
- Redirect and illegal in the same cycle: the redirect wins and there is no halt, because the illegal instruction is squashed.
- Load-use and illegal in the same cycle: the stall wins and illegal is re-evaluated next cycle.
- MEM_WAIT:
  - `if_stall_o`=`id_stall_o`=`ex_stall_o`=1.
  - No flush or redirect is issued while stalled. A held `ex_branch_taken_i`/`ex_jump_i` acts on the first cycle back in RUN.
  - Transition to RUN in the cycle `lsu_gnt_i`=1. In that cycle stalls are 0 and the RUN rules apply combinationally.
- HALT:
  - `halted_o`=1, `if_stall_o`=`id_stall_o`=1, `id_flush_o`=1, `ex_stall_o`=memstall (older instructions drain).
  - Exit is by reset only.
- `stall_cycles_o`: +1 in every RUN or MEM_WAIT cycle with `if_stall_o`=1. It does not count in BOOT or HALT.
- `flush_count_o`: +1 per cycle with `pc_redirect_o`=1.
- Both counters saturate at all-ones and never wrap.

## Timing
- All outputs are combinational from the registered state and the current inputs. State and counters update on posedge `clk_i`.
- During reset: `if_stall_o`=1, `id_stall_o`=1, `id_flush_o`=1, `ex_stall_o`=0, `if_flush_o`=0, `pc_redirect_o`=0, `halted_o`=0, counters 0.
- A reset assertion mid-MEM_WAIT or mid-HALT returns immediately to BOOT (asynchronous) and clears the counters.
- Load-use penalty: exactly 1 cycle. Redirect penalty: 2 bubbles (IF/ID plus ID/EX).
- MEM_WAIT latency equals the number of cycles `lsu_gnt_i` stays low. `lsu_gnt_i` in the same cycle as `lsu_req_i` costs 0 cycles.

## Test plan
- Reset release with BootCycles=2: `if_stall_o`=1 for exactly 2 cycles, RUN on the 3rd, counters remain 0.
- `ex_load_i`=1, `ex_rd_addr_i`=5, `id_rs2_addr_i`=5, rs2_used=1: one cycle of `if_stall_o`/`id_stall_o`/`id_flush_o`, `stall_cycles_o`=1. Repeat with rd=0, or with rs2_used=0: no stall.
- `lsu_req_i`=1 with `lsu_gnt_i` low for 3 cycles: all three stalls high for 3 cycles, `stall_cycles_o`=3. A `ex_branch_taken_i` held during the wait gives `pc_redirect_o` only in the gnt cycle, and `flush_count_o`=1.
- `ex_jump_i`=1 together with `id_illegal_instr_i`=1: redirect plus both flushes, `halted_o` stays 0.
- `id_illegal_instr_i`=1 alone: `halted_o`=1 from the next cycle. A later `lsu_req_i` without gnt raises only `ex_stall_o`. Asserting `rst_ni`=0 mid-HALT returns to the BOOT outputs.
- Force `stall_cycles_o` to the all-ones value minus 1 via a sustained load-use/memstall pattern with CntWidth=4: it reaches 15 and holds at 15.
